// File: rtl/sr_latch_driver.sv
// Write sequencer for an external SR latch: drives S/R, pulses Enable,
// then checks the synchronized Q/Qbar readback against the written value.
// Done is high during the (1 + PULSE_W + SETTLE + 1)th cycle after the
// accept edge; Req_Ready returns on the cycle after Done.
module sr_latch_driver #(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned SETTLE  = 2
) (
    input  logic       Clock,
    input  logic       Clear,
    input  logic       Req_Valid,
    input  logic       Req_Value,
    output logic       Req_Ready,
    output logic       S,
    output logic       R,
    output logic       Enable,
    input  logic       Q_fb,
    input  logic       Qbar_fb,
    output logic       Done,
    output logic       Error,
    output logic [7:0] Err_Count
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned ERR_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        CHECK = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             val;
    logic             val_nxt;
    logic [1:0]       q_sync;
    logic [1:0]       qb_sync;
    logic             s_nxt;
    logic             r_nxt;
    logic             en_nxt;
    logic             done_nxt;
    logic             err_nxt;
    logic             ready_nxt;
    logic             mismatch_c;

    // Readback is wrong if Q disagrees with the written value or Q == Qbar.
    assign mismatch_c = (q_sync[1] != val) || (q_sync[1] == qb_sync[1]);

    // Two-flop synchronizers for the asynchronous latch readback.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            q_sync  <= 2'b00;
            qb_sync <= 2'b00;
        end else begin
            q_sync  <= {q_sync[0], Q_fb};
            qb_sync <= {qb_sync[0], Qbar_fb};
        end
    end

    // Next-state and next-output decode; outputs registered so they track the state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        val_nxt   = val;
        s_nxt     = 1'b0;
        r_nxt     = 1'b0;
        en_nxt    = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (Req_Valid && Req_Ready) begin
                    val_nxt   = Req_Value;
                    state_nxt = SETUP;
                    s_nxt     = Req_Value;
                    r_nxt     = ~Req_Value;
                end
            end
            SETUP: begin
                state_nxt = PULSE;
                cnt_nxt   = CNT_W'(PULSE_W - 1);
                s_nxt     = val;
                r_nxt     = ~val;
                en_nxt    = 1'b1;
            end
            PULSE: begin
                // S/R stay put across the Enable falling edge (first HOLD cycle).
                s_nxt = val;
                r_nxt = ~val;
                if (cnt == '0) begin
                    state_nxt = HOLD;
                    cnt_nxt   = CNT_W'(SETTLE - 1);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                    en_nxt  = 1'b1;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_nxt = CHECK;
                    done_nxt  = 1'b1;
                    err_nxt   = mismatch_c;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            CHECK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        ready_nxt = (state_nxt == IDLE);
    end

    // State, counter, captured value and registered outputs.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state     <= IDLE;
            cnt       <= '0;
            val       <= 1'b0;
            S         <= 1'b0;
            R         <= 1'b0;
            Enable    <= 1'b0;
            Done      <= 1'b0;
            Error     <= 1'b0;
            Req_Ready <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            val       <= val_nxt;
            S         <= s_nxt;
            R         <= r_nxt;
            Enable    <= en_nxt;
            Done      <= done_nxt;
            Error     <= err_nxt;
            Req_Ready <= ready_nxt;
        end
    end

    // Saturating count of writes that ended in a readback error.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            Err_Count <= '0;
        end else if (done_nxt && err_nxt && (Err_Count != {ERR_W{1'b1}})) begin
            Err_Count <= Err_Count + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: behavioural SR latch, queued expectations,
// a Done-driven checker and a per-cycle S/R/Enable protocol watcher.
module tb_sr_latch_driver;

    localparam int unsigned PW  = 2;
    localparam int unsigned ST  = 2;
    localparam int unsigned LAT = 1 + PW + ST + 1;
    localparam time         P   = 10;

    logic       Clock = 1'b0;
    logic       Clear = 1'b0;
    logic       Req_Valid = 1'b0;
    logic       Req_Value = 1'b0;
    logic       Req_Ready;
    logic       S;
    logic       R;
    logic       Enable;
    logic       Q_fb;
    logic       Qbar_fb;
    logic       Done;
    logic       Error;
    logic [7:0] Err_Count;

    sr_latch_driver #(.PULSE_W(PW), .SETTLE(ST)) dut (
        .Clock     (Clock),
        .Clear     (Clear),
        .Req_Valid (Req_Valid),
        .Req_Value (Req_Value),
        .Req_Ready (Req_Ready),
        .S         (S),
        .R         (R),
        .Enable    (Enable),
        .Q_fb      (Q_fb),
        .Qbar_fb   (Qbar_fb),
        .Done      (Done),
        .Error     (Error),
        .Err_Count (Err_Count)
    );

    always #(P / 2) Clock = ~Clock;

    typedef struct {
        logic       err;
        logic [7:0] cnt;
        time        t;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   viol  = 0;
    int   exp_cnt = 0;
    int   mode = 0;        // 0: healthy latch, 1: Q stuck at 0, 2: Q and Qbar both 1
    int   s_hi = 0;
    int   r_hi = 0;
    int   en_hi = 0;
    logic lq = 1'b0;
    logic ps = 1'b0;
    logic pr = 1'b0;

    // Behavioural SR latch, transparent while Enable is high.
    always @(S, R, Enable) begin
        if (Enable) begin
            if (S) lq = 1'b1;
            else if (R) lq = 1'b0;
        end
    end

    assign Q_fb    = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : lq;
    assign Qbar_fb = (mode == 2) ? 1'b1 : ~lq;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Readback seen after writing v under the current fault mode.
    function automatic logic model_err(input logic v, input int m);
        logic q;
        logic qb;
        q  = (m == 1) ? 1'b0 : (m == 2) ? 1'b1 : v;
        qb = (m == 2) ? 1'b1 : ~v;
        return (q != v) || (q == qb);
    endfunction

    // Done-driven checker.
    always @(negedge Clock) begin
        exp_t e;
        if (Done) begin
            if (sbq.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sbq.pop_front();
                check("done_time", longint'($time), longint'(e.t));
                check("error", longint'(Error), longint'(e.err));
                check("err_count", longint'(Err_Count), longint'(e.cnt));
            end
        end
    end

    // Protocol watcher: never S&R, never an S/R change while Enable is high.
    always @(negedge Clock) begin
        if (S && R) begin
            viol++;
            if (viol < 5) $display("FAIL s_and_r: S=%0b R=%0b at %0t", S, R, $time);
        end
        if (Enable && ((S != ps) || (R != pr))) begin
            viol++;
            if (viol < 5) $display("FAIL sr_change_while_enable: S=%0b R=%0b was %0b%0b at %0t",
                                   S, R, ps, pr, $time);
        end
        ps = S;
        pr = R;
        if (S) s_hi++;
        if (R) r_hi++;
        if (Enable) en_hi++;
    end

    // Issue one write (call at a negedge); returns the accept-edge time.
    task automatic write(input logic v, input bit hold, output time t0);
        int n;
        exp_t e;
        n = 0;
        Req_Valid = 1'b1;
        Req_Value = v;
        while (!Req_Ready && n < 50) begin
            @(negedge Clock);
            n++;
        end
        if (!Req_Ready) begin
            check("ready_timeout", 0, 1);
            Req_Valid = 1'b0;
            t0 = 0;
            return;
        end
        @(posedge Clock);
        t0 = $time;
        if (model_err(v, mode) && exp_cnt < 255) exp_cnt++;
        e.err = model_err(v, mode);
        e.cnt = 8'(exp_cnt);
        e.t   = t0 + (LAT - 1) * P + P / 2;
        sbq.push_back(e);
        @(negedge Clock);
        if (!hold) Req_Valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge Clock);
            n++;
        end
        if (sbq.size() != 0) check("drain_timeout", longint'(sbq.size()), 0);
        @(negedge Clock);
    endtask

    initial begin
        #(200000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        time t1;
        time t2;
        logic v;
        int gap;

        // Reset values
        #12;
        check("rst_ready", longint'(Req_Ready), 0);
        check("rst_s", longint'(S), 0);
        check("rst_r", longint'(R), 0);
        check("rst_enable", longint'(Enable), 0);
        check("rst_done", longint'(Done), 0);
        check("rst_error", longint'(Error), 0);
        check("rst_err_count", longint'(Err_Count), 0);
        @(negedge Clock);
        Clear = 1'b1;
        @(posedge Clock);
        #1;
        check("ready_after_reset", longint'(Req_Ready), 1);
        @(negedge Clock);

        // Single write of 1
        s_hi = 0; r_hi = 0; en_hi = 0;
        write(1'b1, 1'b0, t1);
        drain();
        check("w1_s_cycles", s_hi, 1 + PW + 1);
        check("w1_r_cycles", r_hi, 0);
        check("w1_enable_cycles", en_hi, PW);
        check("w1_latch", longint'(lq), 1);

        // Back-to-back 1 then 0 with Req_Valid held
        s_hi = 0; r_hi = 0; en_hi = 0;
        write(1'b1, 1'b1, t1);
        write(1'b0, 1'b0, t2);
        check("b2b_accept_gap", longint'(t2 - t1), longint'((LAT + 1) * P));
        drain();
        check("b2b_s_cycles", s_hi, 1 + PW + 1);
        check("b2b_r_cycles", r_hi, 1 + PW + 1);
        check("b2b_latch", longint'(lq), 0);

        // Randomized writes under random fault modes
        for (int b = 0; b < 5; b++) begin
            mode = int'($urandom_range(0, 2));
            for (int k = 0; k < 8; k++) begin
                v   = 1'($urandom_range(0, 1));
                gap = int'($urandom_range(0, 3));
                write(v, (gap == 0) && (k != 7), t1);
                if (gap != 0) repeat (gap) @(negedge Clock);
            end
            drain();
        end

        // Q and Qbar both high, write 0
        mode = 2;
        write(1'b0, 1'b0, t1);
        drain();
        mode = 0;

        // Reset in the middle of PULSE
        write(1'b1, 1'b0, t1);
        @(posedge Clock);
        #2;
        check("pulse_enable_high", longint'(Enable), 1);
        Clear = 1'b0;
        #1;
        check("abort_enable", longint'(Enable), 0);
        check("abort_s", longint'(S), 0);
        check("abort_r", longint'(R), 0);
        check("abort_err_count", longint'(Err_Count), 0);
        sbq.delete();
        exp_cnt = 0;
        repeat (3) @(negedge Clock);
        Clear = 1'b1;
        @(posedge Clock);
        #1;
        check("ready_after_abort", longint'(Req_Ready), 1);
        @(negedge Clock);
        repeat (LAT + 2) @(negedge Clock);

        // Q stuck at 0: 300 writes of 1, count saturates at 255
        mode = 1;
        for (int k = 0; k < 300; k++) begin
            write(1'b1, k != 299, t1);
        end
        drain();
        check("err_count_saturated", longint'(Err_Count), 255);
        mode = 0;

        check("protocol_violations", viol, 0);
        check("scoreboard_empty", longint'(sbq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
